// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// IFU_HALT_DETECT_EN (optional) enables halt-on-zero-word detection in the top.
package ifu_pkg;

    localparam int IFU_ADDR_W  = 16;
    localparam int IFU_INSTR_W = 16;
    localparam int PC_INCR     = 2;
    localparam int QUEUE_DEPTH = 2;
    localparam logic [IFU_INSTR_W-1:0] HALT_WORD = 16'h0000;

    typedef enum logic [1:0] {
        IFU_IDLE,
        IFU_RUN,
        IFU_HALTED
    } ifu_state_t;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0]  pc;
        logic [IFU_INSTR_W-1:0] instr;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// Small FIFO of fetched {pc, instr} entries; flush overrides push and pop.
// A push into a full queue is accepted only when a pop frees a slot that cycle.
module ifu_queue
    import ifu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  ifu_entry_t wdata,
    output ifu_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    ifu_entry_t       mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(QUEUE_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads 16-bit words from byte memory, queues them for decode.
// Define IFU_HALT_DETECT_EN to stop fetching after an all-zero (erased) word.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = IFU_ADDR_W,
    parameter int                    INSTR_WIDTH = IFU_INSTR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    output logic                   MEM_RD_EN,
    output logic [ADDR_WIDTH-1:0]  MEM_ADDR,
    input  logic [INSTR_WIDTH-1:0] MEM_RDATA,
    input  logic                   REDIRECT_VALID,
    input  logic [ADDR_WIDTH-1:0]  REDIRECT_PC,
    output logic                   INSTR_VALID,
    output logic [INSTR_WIDTH-1:0] INSTR,
    output logic [ADDR_WIDTH-1:0]  INSTR_PC,
    input  logic                   INSTR_READY,
    output logic                   FETCH_HALTED
);

    ifu_state_t            state;
    ifu_state_t            next_state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  redirect_take;
    logic                  pop;
    logic                  halt_hit;
    logic                  q_full;
    logic                  q_empty;
    ifu_entry_t            q_wdata;
    ifu_entry_t            q_head;

    // Redirect is ignored during the memory preload window.
    assign redirect_take = REDIRECT_VALID && (state != IFU_IDLE);
    assign pop           = INSTR_VALID && INSTR_READY;
    assign MEM_ADDR      = pc;

`ifdef IFU_HALT_DETECT_EN
    assign halt_hit = MEM_RD_EN && (MEM_RDATA == HALT_WORD);
`else
    assign halt_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= IFU_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IFU_IDLE:   next_state = IFU_RUN;
            IFU_RUN:    if (!redirect_take && halt_hit) next_state = IFU_HALTED;
            IFU_HALTED: if (redirect_take) next_state = IFU_RUN;
            default:    next_state = IFU_IDLE;
        endcase
    end

    always_comb begin
        MEM_RD_EN    = (state == IFU_RUN) && !redirect_take && (!q_full || pop);
`ifdef IFU_HALT_DETECT_EN
        FETCH_HALTED = (state == IFU_HALTED);
`else
        FETCH_HALTED = 1'b0;
`endif
    end

    // PC wraps modulo 2^ADDR_WIDTH; a halt word freezes it on its own address + 0.
    always_ff @(posedge CLK) begin
        if (RST)                        pc <= RESET_PC;
        else if (redirect_take)         pc <= {REDIRECT_PC[ADDR_WIDTH-1:1], 1'b0};
        else if (MEM_RD_EN && !halt_hit) pc <= pc + ADDR_WIDTH'(PC_INCR);
    end

    assign q_wdata.pc    = pc;
    assign q_wdata.instr = MEM_RDATA;

    ifu_queue u_queue (
        .clk   (CLK),
        .rst   (RST),
        .push  (MEM_RD_EN),
        .pop   (pop),
        .flush (redirect_take),
        .wdata (q_wdata),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign INSTR_VALID = !q_empty;
    assign INSTR       = q_empty ? '0 : q_head.instr;
    assign INSTR_PC    = q_empty ? '0 : q_head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: stimulus loads the expected word stream on reset/redirect; a negedge monitor checks.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        MEM_RD_EN;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_RDATA;
    logic        REDIRECT_VALID = 1'b0;
    logic [15:0] REDIRECT_PC = '0;
    logic        INSTR_VALID;
    logic [15:0] INSTR;
    logic [15:0] INSTR_PC;
    logic        INSTR_READY = 1'b1;
    logic        FETCH_HALTED;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:65535];

    typedef struct {
        logic [15:0] pc;
        logic [15:0] w;
    } exp_t;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    assign MEM_RDATA = {mem[MEM_ADDR + 16'd1], mem[MEM_ADDR]};

    instruction_fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .MEM_RD_EN      (MEM_RD_EN),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_RDATA      (MEM_RDATA),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .INSTR_VALID    (INSTR_VALID),
        .INSTR          (INSTR),
        .INSTR_PC       (INSTR_PC),
        .INSTR_READY    (INSTR_READY),
        .FETCH_HALTED   (FETCH_HALTED)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {mem[a + 16'd1], mem[a]};
    endfunction

    // Program order from a start address: consecutive even addresses, wrapping, ending at a halt word if enabled.
    task automatic load_stream(input logic [15:0] start);
        logic [15:0] p;
        exp_t e;
        exp_q.delete();
        p = start & 16'hFFFE;
        for (int i = 0; i < 48; i++) begin
            e.pc = p;
            e.w  = word_at(p);
            exp_q.push_back(e);
`ifdef IFU_HALT_DETECT_EN
            if (e.w == 16'h0000) break;
`endif
            p = p + 16'd2;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic redirect(input logic [15:0] t);
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = t;
        load_stream(t);
        tick();
        REDIRECT_VALID = 1'b0;
    endtask

    task automatic reset_pulse(input int n);
        RST = 1'b1;
        load_stream(16'h0000);
        repeat (n) tick();
        RST = 1'b0;
    endtask

    // Monitor
    logic        prev_rst = 1'b0;
    logic        prev_redir = 1'b0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_tgt = '0;
    logic [15:0] hold_instr = '0;
    logic [15:0] hold_pc = '0;

    always @(negedge CLK) begin
        exp_t e;
        if (prev_rst) begin
            chk("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
            chk("rst_rden", {31'd0, MEM_RD_EN}, 32'd0);
            chk("rst_instr", {16'd0, INSTR}, 32'd0);
            chk("rst_pc", {16'd0, INSTR_PC}, 32'd0);
            chk("rst_addr", {16'd0, MEM_ADDR}, 32'd0);
            chk("rst_halted", {31'd0, FETCH_HALTED}, 32'd0);
        end else if (prev_redir) begin
            chk("flush_valid", {31'd0, INSTR_VALID}, 32'd0);
            chk("redir_addr", {16'd0, MEM_ADDR}, {16'd0, prev_tgt});
        end else if (prev_hold) begin
            chk("hold_stable", {INSTR_PC, INSTR}, {hold_pc, hold_instr});
            chk("hold_valid", {31'd0, INSTR_VALID}, 32'd1);
        end
        if (!RST) begin
            chk("addr_even", {31'd0, MEM_ADDR[0]}, 32'd0);
            if (REDIRECT_VALID)
                chk("redir_rden", {31'd0, MEM_RD_EN}, 32'd0);
            else if (INSTR_VALID && INSTR_READY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {INSTR_PC, INSTR}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {INSTR_PC, INSTR}, {e.pc, e.w});
                end
            end
        end
`ifndef IFU_HALT_DETECT_EN
        chk("no_halt", {31'd0, FETCH_HALTED}, 32'd0);
`endif
        prev_rst   = RST;
        prev_redir = !RST && REDIRECT_VALID;
        prev_tgt   = REDIRECT_PC & 16'hFFFE;
        prev_hold  = !RST && !REDIRECT_VALID && INSTR_VALID && !INSTR_READY;
        hold_instr = INSTR;
        hold_pc    = INSTR_PC;
    end

    function automatic logic [15:0] pick_target();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h0024;
            2:       return 16'h0025;
            3:       return 16'h0032;
            4:       return 16'hFFFE;
            default: return 16'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        int k;
        int since_rst;
        int seg;
        int r;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[0] = 8'h2f; mem[1] = 8'h01; mem[2] = 8'h2e; mem[3] = 8'h01;
        mem[4] = 8'h4c; mem[5] = 8'h03; mem[6] = 8'h2d; mem[7] = 8'h03;
        for (int i = 8; i < 36; i++) mem[i] = 8'($urandom_range(1, 255));
        for (int i = 38; i < 50; i++) mem[i] = 8'($urandom_range(1, 255));
        mem[36] = 8'h90; mem[37] = 8'h88; mem[50] = 8'hcf; mem[51] = 8'heb;

        // 1: streaming after reset, first valid two cycles after release
        INSTR_READY = 1'b1;
        reset_pulse(3);
        k = 0;
        while (k < 5) begin
            @(negedge CLK);
            if (INSTR_VALID) break;
            k++;
        end
        chk("first_valid_cycle", k, 32'd2);
        tick();
        repeat (6) tick();

        // 2: decode stalled from reset, queue fills and fetch stops
        INSTR_READY = 1'b0;
        reset_pulse(1);
        repeat (5) tick();
        @(negedge CLK);
        chk("full_rden", {31'd0, MEM_RD_EN}, 32'd0);
        chk("full_head", {15'd0, INSTR_VALID, INSTR}, {15'd0, 1'b1, 16'h012f});
        chk("full_head_pc", {16'd0, INSTR_PC}, 32'd0);
        tick();
        INSTR_READY = 1'b1;
        repeat (4) tick();

        // 3: redirect with the queue full
        INSTR_READY = 1'b0;
        repeat (3) tick();
        redirect(16'h0024);
        INSTR_READY = 1'b1;
        repeat (5) tick();

        // 4: odd redirect target
        redirect(16'h0025);
        repeat (5) tick();

        // 5: erased-memory word
        redirect(16'h0032);
        repeat (6) tick();
        @(negedge CLK);
`ifdef IFU_HALT_DETECT_EN
        chk("halted", {31'd0, FETCH_HALTED}, 32'd1);
        chk("halted_rden", {31'd0, MEM_RD_EN}, 32'd0);
        chk("halted_empty", {31'd0, INSTR_VALID}, 32'd0);
`else
        chk("not_halted", {31'd0, FETCH_HALTED}, 32'd0);
        chk("running_rden", {31'd0, MEM_RD_EN}, 32'd1);
`endif
        tick();
        redirect(16'h0000);
        @(negedge CLK);
        chk("unhalted", {31'd0, FETCH_HALTED}, 32'd0);
        tick();
        repeat (4) tick();

        // 6: PC wrap, then reset mid-stream
        redirect(16'hFFFE);
        repeat (3) tick();
        reset_pulse(1);
        repeat (6) tick();

        // Random traffic
        since_rst = 10;
        seg = 0;
        for (int c = 0; c < 1500; c++) begin
            INSTR_READY = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (since_rst >= 2 && r < 2) begin
                reset_pulse(1);
                since_rst = 0;
                seg = 0;
            end else if (since_rst >= 1 && (r < 10 || seg >= 36)) begin
                redirect(pick_target());
                since_rst++;
                seg = 0;
            end else begin
                tick();
                since_rst++;
                seg++;
            end
        end
        INSTR_READY = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
